// File: rtl/dmem_pkg.sv
// Shared types and sizing for the data-memory responder.
// Holds the FSM state encoding and default parameters.
package dmem_pkg;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 32;
  localparam int TAG_W_DEF  = 8;
  localparam int RD_LAT_DEF = 2;
  localparam int CNT_W      = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RWAIT = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_resp_if.sv
// Request/response handshake bundle between the memory stage
// and the data-memory responder.
interface dmem_resp_if
  import dmem_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [TAG_W-1:0]  req_tag;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_we;
  logic [DATA_W-1:0] rsp_rdata;
  logic [TAG_W-1:0]  rsp_tag;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_we,
    input  rsp_rdata, rsp_tag
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_we,
    output rsp_rdata, rsp_tag
  );

endinterface

// File: rtl/dmem_array.sv
// 256 x 32 single-port storage, synchronous write.
// Read is combinational; the parent registers it.
module dmem_array
  import dmem_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: one outstanding request, stores
// answer next cycle, loads after RD_LAT cycles.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  dmem_resp_if.slave  bus
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              accept;

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign accept        = bus.req_valid && (state == IDLE);

  // In IDLE the live request address drives the port so that
  // RD_LAT=1 loads and stores see the array on the accept edge.
  assign mem_addr = (state == IDLE) ? bus.req_addr : addr_q;

  dmem_array u_array (
    .clk   (clk),
    .we    (accept && bus.req_we),
    .addr  (mem_addr),
    .wdata (bus.req_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      addr_q        <= '0;
      bus.rsp_we    <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_tag   <= TAG_W'(0);
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q      <= bus.req_addr;
            bus.rsp_we  <= bus.req_we;
            bus.rsp_tag <= bus.req_tag;
            if (bus.req_we) begin
              bus.rsp_rdata <= bus.req_wdata;
              state         <= RESP;
            end else if (RD_LAT == 1) begin
              bus.rsp_rdata <= mem_rdata;
              state         <= RESP;
            end else begin
              cnt   <= CNT_W'(RD_LAT - 2);
              state <= RWAIT;
            end
          end
        end
        RWAIT: begin
          if (cnt == '0) begin
            bus.rsp_rdata <= mem_rdata;
            state         <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: vector table with a
// response scoreboard, plus latency and reset sequences.
module tb_dmem_resp;
  import dmem_pkg::*;

  logic clk;
  logic rst;
  logic aux_valid;

  int checks   = 0;
  int failures = 0;

  dmem_resp_if #(.TAG_W(8)) m ();
  dmem_resp_if #(.TAG_W(8)) a1 ();
  dmem_resp_if #(.TAG_W(8)) a4 ();

  dmem_resp #(.RD_LAT(2), .TAG_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (m)
  );

  dmem_resp #(.RD_LAT(1), .TAG_W(8)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (a1)
  );

  dmem_resp #(.RD_LAT(4), .TAG_W(8)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (a4)
  );

  assign a1.req_valid = aux_valid;
  assign a1.req_we    = m.req_we;
  assign a1.req_addr  = m.req_addr;
  assign a1.req_wdata = m.req_wdata;
  assign a1.req_tag   = m.req_tag;
  assign a1.rsp_ready = 1'b1;

  assign a4.req_valid = aux_valid;
  assign a4.req_we    = m.req_we;
  assign a4.req_addr  = m.req_addr;
  assign a4.req_wdata = m.req_wdata;
  assign a4.req_tag   = m.req_tag;
  assign a4.rsp_ready = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [31:0] rdata;
    logic [7:0]  tag;
  } exp_t;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  tag;
    logic [31:0] exp;
    int          lat;
    int          hold;
  } vec_t;

  exp_t sb[$];
  vec_t vt[10];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic txn(input logic        we,
                     input logic [7:0]  addr,
                     input logic [31:0] wdata,
                     input logic [7:0]  tag,
                     input logic [31:0] exp_rdata,
                     input int          exp_lat,
                     input int          hold);
    exp_t e;
    int   lat;
    check("req_ready_idle", m.req_ready, 1);
    m.req_valid = 1'b1;
    m.req_we    = we;
    m.req_addr  = addr;
    m.req_wdata = wdata;
    m.req_tag   = tag;
    sb.push_back('{we: we, rdata: exp_rdata, tag: tag});
    @(posedge clk); #1;
    m.req_valid = 1'b0;
    lat = 1;
    while (!m.rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check("rsp_valid", m.rsp_valid, 1);
    check("latency", lat, exp_lat);
    e = sb.pop_front();
    check("rsp_rdata", m.rsp_rdata, e.rdata);
    check("rsp_we", m.rsp_we, e.we);
    check("rsp_tag", m.rsp_tag, e.tag);
    if (hold > 0) begin
      m.req_valid = 1'b1;
      m.req_we    = 1'b1;
      m.req_wdata = 32'h0BAD0BAD;
      m.req_tag   = 8'hEE;
      repeat (hold) begin
        @(posedge clk); #1;
        check("hold_valid", m.rsp_valid, 1);
        check("hold_ready", m.req_ready, 0);
        check("hold_rdata", m.rsp_rdata, e.rdata);
        check("hold_we", m.rsp_we, e.we);
        check("hold_tag", m.rsp_tag, e.tag);
      end
    end
    m.rsp_ready = 1'b1;
    @(posedge clk); #1;
    m.rsp_ready = 1'b0;
    m.req_valid = 1'b0;
    check("ret_ready", m.req_ready, 1);
    check("ret_valid", m.rsp_valid, 0);
  endtask

  task automatic aux_txn(input logic        we,
                         input logic [7:0]  addr,
                         input logic [31:0] wdata,
                         input logic [7:0]  tag,
                         input logic [31:0] exp_rdata,
                         input int          exp_lat4);
    int          l1;
    int          l4;
    logic [31:0] d1;
    logic [31:0] d4;
    logic        w1;
    logic        w4;
    logic [7:0]  t4;
    l1 = 0; l4 = 0;
    d1 = '0; d4 = '0;
    w1 = 1'bx; w4 = 1'bx; t4 = '0;
    check("aux1_ready", a1.req_ready, 1);
    check("aux4_ready", a4.req_ready, 1);
    m.req_we    = we;
    m.req_addr  = addr;
    m.req_wdata = wdata;
    m.req_tag   = tag;
    aux_valid   = 1'b1;
    @(posedge clk); #1;
    aux_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (a1.rsp_valid && l1 == 0) begin
        l1 = c; d1 = a1.rsp_rdata; w1 = a1.rsp_we;
      end
      if (a4.rsp_valid && l4 == 0) begin
        l4 = c; d4 = a4.rsp_rdata;
        w4 = a4.rsp_we; t4 = a4.rsp_tag;
      end
      @(posedge clk); #1;
    end
    check("aux1_lat", l1, 1);
    check("aux4_lat", l4, exp_lat4);
    check("aux1_rdata", d1, exp_rdata);
    check("aux4_rdata", d4, exp_rdata);
    check("aux1_we", w1, we);
    check("aux4_we", w4, we);
    check("aux4_tag", t4, tag);
  endtask

  int nrise;

  initial begin
    vt[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 8'h35, 32'hDEADBEEF, 1, 0};
    vt[1] = '{1'b0, 8'h10, 32'h0,        8'h12, 32'hDEADBEEF, 2, 0};
    vt[2] = '{1'b1, 8'hFF, 32'h1,        8'h21, 32'h1,        1, 0};
    vt[3] = '{1'b1, 8'h00, 32'h2,        8'h22, 32'h2,        1, 0};
    vt[4] = '{1'b0, 8'hFF, 32'h0,        8'h13, 32'h1,        2, 0};
    vt[5] = '{1'b0, 8'h00, 32'h0,        8'h14, 32'h2,        2, 0};
    vt[6] = '{1'b0, 8'h10, 32'h0,        8'h15, 32'hDEADBEEF, 2, 5};
    vt[7] = '{1'b0, 8'h10, 32'h0,        8'h16, 32'hDEADBEEF, 2, 0};
    vt[8] = '{1'b1, 8'h10, 32'h12345678, 8'h37, 32'h12345678, 1, 0};
    vt[9] = '{1'b0, 8'h10, 32'h0,        8'h17, 32'h12345678, 2, 0};

    rst         = 1'b0;
    aux_valid   = 1'b0;
    m.req_valid = 1'b0;
    m.req_we    = 1'b0;
    m.req_addr  = '0;
    m.req_wdata = '0;
    m.req_tag   = '0;
    m.rsp_ready = 1'b0;
    #3;
    check("rst_req_ready", m.req_ready, 1);
    check("rst_rsp_valid", m.rsp_valid, 0);
    check("rst_rsp_we", m.rsp_we, 0);
    check("rst_rsp_rdata", m.rsp_rdata, 0);
    check("rst_rsp_tag", m.rsp_tag, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    aux_txn(1'b1, 8'h10, 32'hDEADBEEF, 8'h35, 32'hDEADBEEF, 1);
    aux_txn(1'b0, 8'h10, 32'h0, 8'h36, 32'hDEADBEEF, 4);

    for (int i = 0; i < 10; i++)
      txn(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].tag,
          vt[i].exp, vt[i].lat, vt[i].hold);

    // Reset while a store response is pending; write must persist.
    m.req_valid = 1'b1;
    m.req_we    = 1'b1;
    m.req_addr  = 8'h40;
    m.req_wdata = 32'hCAFEF00D;
    m.req_tag   = 8'h41;
    @(posedge clk); #1;
    m.req_valid = 1'b0;
    check("st_abort_valid", m.rsp_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("st_abort_ready", m.req_ready, 1);
    check("st_abort_rvalid", m.rsp_valid, 0);
    check("st_abort_we", m.rsp_we, 0);
    check("st_abort_rdata", m.rsp_rdata, 0);
    check("st_abort_tag", m.rsp_tag, 0);
    @(posedge clk); #1 rst = 1'b1;

    // Reset during the load wait; no response may ever appear.
    check("ld_abort_pre", m.req_ready, 1);
    m.req_valid = 1'b1;
    m.req_we    = 1'b0;
    m.req_addr  = 8'h10;
    m.req_tag   = 8'h42;
    @(posedge clk); #1;
    m.req_valid = 1'b0;
    check("ld_abort_rwait", m.rsp_valid, 0);
    check("ld_abort_busy", m.req_ready, 0);
    #2 rst = 1'b0;
    #1;
    check("ld_abort_ready", m.req_ready, 1);
    check("ld_abort_rvalid", m.rsp_valid, 0);
    @(posedge clk); #1 rst = 1'b1;
    nrise = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (m.rsp_valid) nrise++;
    end
    check("ld_abort_norsp", nrise, 0);

    txn(1'b0, 8'h40, 32'h0, 8'h43, 32'hCAFEF00D, 2, 0);
    txn(1'b0, 8'h10, 32'h0, 8'h44, 32'h12345678, 2, 0);
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
